alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one ALU instance between two requesters (r0: execute stage, r1: address/branch helper).
//  Round-robin arbitration, valid/ready request and response handshakes, registered result.
//  Sits in the datapath between the requesters and the single combinational ALU (module ALU).
// PARAMETERS
//  DATA_W  32  operand/result width (must be 32; matches ALU)
//  OP_W    4   ALU opcode width
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  r0_req_valid in   1       requester 0 has an operation
//  r0_req_ready out  1       arbiter accepts r0 operation this cycle
//  r0_a, r0_b   in   DATA_W  r0 operands
//  r0_op        in   OP_W    r0 ALU opcode
//  r1_req_valid in   1       r1 request valid (same as r0)
//  r1_req_ready out  1       r1 accept
//  r1_a, r1_b   in   DATA_W  r1 operands
//  r1_op        in   OP_W    r1 ALU opcode
//  r0_rsp_valid out  1       result for r0 available
//  r0_rsp_ready in   1       r0 consumes result
//  r1_rsp_valid out  1       result for r1 available
//  r1_rsp_ready in   1       r1 consumes result
//  rsp_result   out  DATA_W  registered ALU result (shared by both responses)
//  rsp_zero     out  1       registered zero flag (rsp_result==0)
// BEHAVIOUR
//  - FSM: IDLE -> EXEC -> RESP -> IDLE. One op in flight; no queueing.
//  - IDLE: grant chosen combinationally; only granted rN_req_ready=1; others 0.
//    Handshake (valid&ready) latches a, b, op, grant id; goes to EXEC. No valid: stay IDLE.
//  - EXEC: latched operands drive ALU; result and zero registered at end of cycle; go to RESP.
//  - RESP: rsp_valid of granted id =1, other 0; result/zero held stable until rsp_ready of
//    that id; then IDLE. Ready from non-granted requester ignored.
//  - Latency: accept in cycle N -> rsp_valid in N+2. Max throughput 1 op / 3 cycles.
//  - req_ready=0 in EXEC and RESP for both requesters.
//  - Arbitration: both valid in IDLE -> grant to !last_grant; one valid -> it wins.
//    last_grant updates only on an accepted handshake.
//  - Opcodes per package: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, XOR 1100,
//    SLL 1101, SRL 1110, SRA 1000; any other -> result 0, zero 1. Add/sub wrap mod 2^32.
//  - Reset: state IDLE, last_grant=1 (r0 wins first tie), rsp_result=0, rsp_zero=1,
//    all ready/valid outputs 0 in reset cycle. Reset in EXEC/RESP drops in-flight op; no response.
//  - Request inputs may change freely while not accepted; only the accept cycle is sampled.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined: fixed priority, r0 always wins ties; last_grant unused.
//  Not defined: round-robin as above.
// STRUCTURE
//  Package alu_arb_pkg: ALU opcode localparams (ALU_AND..ALU_SRA), FSM state encoding
//  (S_IDLE, S_EXEC, S_RESP), requester id constants.
//  Sub-module alu_rr_pick: 2-way grant logic (valids, last_grant -> grant id, grant_vld);
//  honours ALU_ARB_FIXED_PRIO_EN. ALU instantiated once inside alu_share_arbiter.
// TESTING
//  1. r0 only: a=5,b=3,op=ADD accept cycle N -> r0_rsp_valid in N+2, result 8, zero 0.
//  2. Both valid from reset, r0 SUB 7-7, r1 OR 0xF0|0x0F -> r0 first (result 0, zero 1),
//     then r1 (0xFF); with ALU_ARB_FIXED_PRIO_EN and both held valid, r0 served every time.
//  3. Both held valid 4 ops -> grants r0,r1,r0,r1; rsp_valid only on granted id.
//  4. r1 holds rsp_ready=0 5 cycles in RESP -> result stable, both req_ready=0, no new accept.
//  5. op=4'b1111, a=9,b=9 -> result 0, zero 1; SRA 0x80000000>>>4 -> 0xF8000000.
//  6. reset asserted in EXEC -> next cycle IDLE, no rsp_valid, rsp_result 0, r0 wins next tie.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - ALU opcodes, arbiter FSM state encoding and requester ids.
package alu_arb_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1101;
    localparam logic [3:0] ALU_SRL = 4'b1110;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic REQ_R0 = 1'b0;
    localparam logic REQ_R1 = 1'b1;

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - 32-bit combinational ALU; unknown opcodes yield result 0 with zero set.
module ALU
    import alu_arb_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_SRA: result = $unsigned($signed(a) >>> b[4:0]);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_rr_pick.sv
// rtl/alu_rr_pick.sv - 2-way grant pick; ALU_ARB_FIXED_PRIO_EN selects fixed r0 priority.
module alu_rr_pick
    import alu_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic grant_vld
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_vld = valid0 | valid1;
        grant     = valid0 ? REQ_R0 : REQ_R1;
    end
`else
    always_comb begin
        grant_vld = valid0 | valid1;
        grant     = REQ_R0;
        // On a tie the requester that did not win last time goes first.
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = REQ_R1;
        end
    end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU between two requesters; ALU_ARB_FIXED_PRIO_EN picks fixed priority.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [OP_W-1:0]   r0_op,
    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [OP_W-1:0]   r1_op,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic              gid_q;
    logic              last_grant;
    logic              grant;
    logic              grant_vld;
    logic              accept;
    logic              rsp_done;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    alu_rr_pick u_pick (
        .valid0     (r0_req_valid),
        .valid1     (r1_req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_vld  (grant_vld)
    );

    ALU u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign rsp_done = (gid_q == REQ_R0) ? r0_rsp_ready : r1_rsp_ready;

    // Handshake outputs are forced low while reset is asserted.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        r0_req_ready = 1'b0;
        r1_req_ready = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    r0_req_ready = grant_vld && (grant == REQ_R0);
                    r1_req_ready = grant_vld && (grant == REQ_R1);
                    if (grant_vld) begin
                        accept     = 1'b1;
                        state_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_next = S_RESP;
                end
                S_RESP: begin
                    r0_rsp_valid = (gid_q == REQ_R0);
                    r1_rsp_valid = (gid_q == REQ_R1);
                    if (rsp_done) begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= REQ_R1;
            gid_q      <= REQ_R0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                gid_q      <= grant;
                last_grant <= grant;
                a_q        <= (grant == REQ_R1) ? r1_a  : r0_a;
                b_q        <= (grant == REQ_R1) ? r1_b  : r0_b;
                op_q       <= (grant == REQ_R1) ? r1_op : r0_op;
            end
            if (state == S_EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
        end
    end

endmodule
